apb_slave_responder: RTL and testbench
======================================

# apb_slave_responder

Synthesizable APB completer that answers transfers issued by the APB master agent through the shared `apb_if`. It holds a byte-strobed register file, inserts a programmable number of wait states and flags address errors on PSLVERR. It also detects master-side protocol violations. It is instantiated on the slave side of `hdl_top`, so master driver/monitor BFMs run against real RTL.

## Interface
- `ADDR_WIDTH`, 32: PADDR width.
- `DATA_WIDTH`, 32: PWDATA/PRDATA width; must be 32 (4 byte lanes).
- `NUM_REGS`, 16: number of 32-bit registers; power of two, ≥ 2.
- `pclk` input 1: sole clock; everything on rising edge.
- `preset` input 1: **reset is synchronous and active-high**; one clock is sufficient.
- `psel` input 1: slave select.
- `penable` input 1: access-phase marker.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input ADDR_WIDTH: byte address.
- `pwdata` input DATA_WIDTH: write data.
- `pstrb` input 4: write byte-lane strobes; ignored on reads.
- `pprot` input 3: accepted, no effect.
- `wait_cycles` input 4: wait states per transfer, sampled in setup phase.
- `prdata` output DATA_WIDTH: read data, valid while `pready`=1.
- `pready` output 1: transfer completes on this cycle's edge.
- `pslverr` output 1: error response, valid while `pready`=1.
- `protocol_err` output 1: sticky violation flag; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, READY. All outputs are registered.
- IDLE with `psel`=1, `penable`=0 (setup):
  - Latch `paddr`, `pwrite`, `pwdata`, `pstrb`.
  - Compute `err` = (`paddr[1:0]`≠0) or (`paddr[ADDR_WIDTH-1:2]` ≥ NUM_REGS).
  - `wait_cycles`=0 → READY; else → WAIT with counter = `wait_cycles`.
- WAIT: `pready`=0. Counter decrements each cycle; at counter==1 → READY. WAIT lasts exactly `wait_cycles` cycles.
- On entry to READY:
  - `prdata` = reg[index] for a valid read; 0 for writes or errors.
  - `pslverr` = `err`.
  - `pready`=1.
- READY with `psel`&`penable`:
  - Valid write: commit lanes where `pstrb[i]`=1; other lanes unchanged.
  - Error write: nothing written.
  - → IDLE; `pready`, `pslverr` and `prdata` return to 0 next cycle.
- Back-to-back transfers: the next setup phase is seen in IDLE. This gives 2 + `wait_cycles` cycles per transfer, the APB minimum.
- Violations set `protocol_err`, FSM → IDLE, no register write:
  - `psel`=1 & `penable`=1 seen in IDLE.
  - `psel` drops in WAIT or READY.
  - `penable`=0 in WAIT or READY.
  - `paddr`/`pwrite` differs from the latched value during WAIT.
- Reset values:
  - State IDLE.
  - `prdata`=0, `pready`=0, `pslverr`=0, `protocol_err`=0.
  - All registers 0.
  - Wait counter 0.
- Reset mid-transfer aborts it with no write. `pready` is 0 on the cycle after `preset` is sampled high.

## Timing
- Setup at cycle T → `pready`=1 during cycle T+1+`wait_cycles` → write commits at the end of that cycle.
- Read data is available in the same cycle as `pready`; there are no bubbles beyond the APB protocol.
- A `wait_cycles` change takes effect only at the next setup phase.
- Counter width is 4 bits; `wait_cycles`=15 gives 15 wait states with no wrap.

## Structure
- `apb_slave_pkg`:
  - State enum `apb_slave_state_e` {IDLE, WAIT, READY}.
  - `STRB_WIDTH`=4.
  - Error-decode helper function (alignment and range check).
- Sub-module `apb_slave_reg_file`:
  - NUM_REGS×32 array.
  - Synchronous byte-strobed write port; combinational read port.
  - Synchronous active-high reset to zero.
- `apb_slave_responder` holds the FSM, wait counter, latches, error/violation logic and output registers.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 (`pstrb`=0xF, `wait_cycles`=0), then read 0x04: write completes in 2 cycles, read returns `prdata`=0xDEADBEEF with `pslverr`=0.
- `wait_cycles`=3, read 0x04: `pready` low for exactly 3 access cycles, high on the 4th, data 0xDEADBEEF.
- Write 0x11223344 to 0x08 with `pstrb`=0x5 over initial 0, then read: returns 0x00220044.
- Write to 0x40 (index 16 ≥ NUM_REGS) and read 0x06 (misaligned):
  - Both get `pslverr`=1 with `pready`.
  - Read `prdata`=0.
  - A re-read of 0x00 still returns its prior value.
- `wait_cycles`=5, drop `psel` in the 2nd wait cycle: `protocol_err`=1, FSM back to IDLE, target register unchanged, next legal transfer completes normally.
- Assert `preset` during WAIT of a write to 0x0C:
  - Next cycle all outputs are 0 and the register reads back 0.
  - `protocol_err` is cleared.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB completer.
// Holds the FSM state enum, strobe width and the address error decode.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slave_state_e;

    localparam int STRB_WIDTH = 4;

    // Misaligned byte offset or word index past the register file.
    function automatic logic addr_err(
        input logic [1:0]  byte_off,
        input logic [63:0] word_idx,
        input int unsigned num_regs
    );
        return (byte_off != 2'b00) || (word_idx >= 64'(num_regs));
    endfunction

endpackage

// File: rtl/apb_slave_reg_file.sv
// Byte-strobed register file with synchronous write and combinational read.
// Ports: clk, rst (sync, active-high), we/waddr/wstrb/wdata, raddr/rdata.
module apb_slave_reg_file
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] waddr,
    input  logic [STRB_WIDTH-1:0]       wstrb,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [$clog2(NUM_REGS)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    regs[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/apb_slave_responder.sv
// APB completer: register file, programmable wait states, PSLVERR on bad
// addresses and a sticky flag for master protocol violations.
// Ports: pclk, preset (sync, active-high), APB slave signals psel/penable/
// pwrite/paddr/pwdata/pstrb/pprot, wait_cycles, and registered outputs
// prdata/pready/pslverr/protocol_err.
module apb_slave_responder
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    input  logic [3:0]            wait_cycles,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  protocol_err
);

    localparam int IDX_W = $clog2(NUM_REGS);

    apb_slave_state_e state, state_n;

    logic [3:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] prdata_n;
    logic                  pready_n;
    logic                  pslverr_n;
    logic                  proto_n;

    logic                  setup;
    logic                  reg_we;
    logic                  err_in;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    // Protection attributes are accepted but carry no meaning here.
    logic unused_pprot;
    assign unused_pprot = ^pprot;

    assign err_in = addr_err(paddr[1:0], 64'(paddr[ADDR_WIDTH-1:2]),
                             NUM_REGS);

    // Zero-wait reads index straight off the bus; otherwise use the latch.
    assign rd_idx = (state == IDLE) ? paddr[IDX_W+1:2]
                                    : addr_q[IDX_W+1:2];

    apb_slave_reg_file #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_reg_file (
        .clk   (pclk),
        .rst   (preset),
        .we    (reg_we),
        .waddr (addr_q[IDX_W+1:2]),
        .wstrb (strb_q),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        prdata_n  = '0;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        proto_n   = protocol_err;
        setup     = 1'b0;
        reg_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel && penable) begin
                    proto_n = 1'b1;
                end else if (psel) begin
                    setup = 1'b1;
                    if (wait_cycles == 4'd0) begin
                        state_n   = READY;
                        pready_n  = 1'b1;
                        pslverr_n = err_in;
                        prdata_n  = (pwrite || err_in) ? '0 : rd_data;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = wait_cycles;
                    end
                end
            end
            WAIT: begin
                if (!psel || !penable || paddr != addr_q ||
                    pwrite != write_q) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                    proto_n = 1'b1;
                end else if (cnt == 4'd1) begin
                    state_n   = READY;
                    cnt_n     = 4'd0;
                    pready_n  = 1'b1;
                    pslverr_n = err_q;
                    prdata_n  = (write_q || err_q) ? '0 : rd_data;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            READY: begin
                state_n = IDLE;
                if (psel && penable) begin
                    reg_we = write_q && !err_q;
                end else begin
                    proto_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            prdata       <= '0;
            pready       <= 1'b0;
            pslverr      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            prdata       <= prdata_n;
            pready       <= pready_n;
            pslverr      <= pslverr_n;
            protocol_err <= proto_n;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= err_in;
        end
    end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Scoreboard bench for apb_slave_responder: directed APB transfers push
// expected {prdata,pslverr}; a negedge monitor pops on every pready.
module tb_apb_slave_responder;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  wait_cycles;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    always #5 pclk = ~pclk;

    apb_slave_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) dut (
        .pclk         (pclk),
        .preset       (preset),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pstrb        (pstrb),
        .pprot        (pprot),
        .wait_cycles  (wait_cycles),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .protocol_err (protocol_err)
    );

    // Monitor: every completed transfer must match the next expectation.
    always @(negedge pclk) begin
        if (pready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pready: prdata=%h pslverr=%b",
                         prdata, pslverr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({prdata, pslverr} !== mon_exp) begin
                    errors++;
                    $display("FAIL response: got prdata=%h pslverr=%b, want prdata=%h pslverr=%b",
                             prdata, pslverr, mon_exp[32:1], mon_exp[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Caller is just past a rising edge; returns just past the edge that
    // completes the transfer, with the bus idle.
    task automatic xfer(input string name, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_waits);
        int n;
        exp_q.push_back({exp_rd, exp_err});
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        tick();
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge pclk);
            if (pready) break;
            n++;
            if (n > 40) break;
        end
        chk({name, "_waits"}, 32'(n), 32'(exp_waits));
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        preset      = 1'b1;
        psel        = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        pstrb       = '0;
        pprot       = 3'd0;
        wait_cycles = 4'd0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_proto", 32'(protocol_err), 32'd0);
        tick();

        // Zero-wait write then read back.
        xfer("wr04", 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        xfer("rd04", 1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

        // Three wait states.
        wait_cycles = 4'd3;
        xfer("rd04_w3", 1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3);
        wait_cycles = 4'd0;

        // Partial strobes over a zero register.
        xfer("wr08", 1'b1, 32'h08, 32'h11223344, 4'h5, 32'h0, 1'b0, 0);
        xfer("rd08", 1'b0, 32'h08, 32'h0, 4'h0, 32'h00220044, 1'b0, 0);

        // Address errors; 0x40 would alias register 0 if not blocked.
        xfer("wr00", 1'b1, 32'h00, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
        xfer("wr40", 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
        xfer("rd06", 1'b0, 32'h06, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        xfer("rd00", 1'b0, 32'h00, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);

        // psel dropped in the second wait cycle of a write to 0x0C.
        wait_cycles = 4'd5;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h12345678;
        pstrb   = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0;
        tick();
        penable = 1'b0;
        @(negedge pclk);
        chk("viol_proto", 32'(protocol_err), 32'd1);
        chk("viol_pready", 32'(pready), 32'd0);
        repeat (6) tick();
        wait_cycles = 4'd0;
        xfer("rd0c_after_viol", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        @(negedge pclk);
        chk("proto_sticky", 32'(protocol_err), 32'd1);
        tick();

        // Reset in the middle of a waited write to 0x0C.
        wait_cycles = 4'd5;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'hCAFEF00D;
        pstrb   = 4'hF;
        tick();
        penable = 1'b1;
        tick();
        preset = 1'b1;
        tick();
        preset  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        chk("mid_rst_pready", 32'(pready), 32'd0);
        chk("mid_rst_pslverr", 32'(pslverr), 32'd0);
        chk("mid_rst_prdata", prdata, 32'd0);
        chk("mid_rst_proto", 32'(protocol_err), 32'd0);
        tick();
        wait_cycles = 4'd0;
        xfer("rd0c_after_rst", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        xfer("rd04_after_rst", 1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 0);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
